// File: rtl/wb_writeback_stage.sv
// MEM/WB pipeline register and register-file write-back driver.
// Ports: clk/rst (sync, active-high); freeze, mem_valid_in, wb_en_in,
//   mem_r_en_in, dest_in, alu_res_in describe the MEM-stage instruction;
//   mem_rsp_valid/mem_rsp_data carry data-memory read data;
//   stall_out holds upstream (combinational); Dest_wb, Result_WB,
//   WriteBackEn drive the register-file write port (registered);
//   timeout_err pulses when a load is abandoned (registered).
module wb_writeback_stage #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  mem_valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_data,
    output logic                  stall_out,
    output logic [REG_ADDR_W-1:0] Dest_wb,
    output logic [DATA_W-1:0]     Result_WB,
    output logic                  WriteBackEn,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
    localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(15);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] pend_dest_q, pend_dest_d;
    logic                  pend_wb_q, pend_wb_d;
    logic                  wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     res_q, res_d;
    logic                  terr_q, terr_d;

    logic                  commit;
    logic [REG_ADDR_W-1:0] commit_dest;
    logic [DATA_W-1:0]     commit_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_dest_q <= '0;
            pend_wb_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            dest_q      <= '0;
            res_q       <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_dest_q <= pend_dest_d;
            pend_wb_q   <= pend_wb_d;
            wb_en_q     <= wb_en_d;
            dest_q      <= dest_d;
            res_q       <= res_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_dest_d = pend_dest_q;
        pend_wb_d   = pend_wb_q;
        terr_d      = 1'b0;
        stall_out   = 1'b0;
        commit      = 1'b0;
        commit_dest = dest_in;
        commit_data = alu_res_in;

        unique case (state_q)
            IDLE: begin
                if (mem_valid_in && !freeze) begin
                    if (!mem_r_en_in) begin
                        commit = wb_en_in;
                    end else if (mem_rsp_valid) begin
                        commit      = wb_en_in;
                        commit_data = mem_rsp_data;
                    end else begin
                        // Capture cycle counts as the first wait cycle
                        stall_out   = 1'b1;
                        state_d     = LOAD_WAIT;
                        cnt_d       = CNT_W'(1);
                        pend_dest_d = dest_in;
                        pend_wb_d   = wb_en_in;
                    end
                end
            end
            LOAD_WAIT: begin
                commit_dest = pend_dest_q;
                commit_data = mem_rsp_data;
                // Response beats the timeout when both land together
                if (mem_rsp_valid) begin
                    commit  = pend_wb_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_out = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // PC writes are dropped entirely; outputs hold on no write
        wb_en_d = commit && (commit_dest != PC_IDX);
        dest_d  = wb_en_d ? commit_dest : dest_q;
        res_d   = wb_en_d ? commit_data : res_q;
    end

    assign WriteBackEn = wb_en_q;
    assign Dest_wb     = dest_q;
    assign Result_WB   = res_q;
    assign timeout_err = terr_q;

endmodule
